// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM. The addi states exist only when MIPS_CTRL_ADDI_EN is defined.
// Latency: Moore outputs decoded from State. In FETCH, IRWrite and PCWrite follow MemReady combinationally.
// Backpressure: each cycle MemReady is low holds FETCH, MEMRD or MEMWR for one more cycle.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BEQ     = 4'd8;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
`endif
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal_q;
    logic       illegal_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        illegal_set = 1'b0;
        case (state_q)
            S_FETCH:   state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            // IR is held after DECODE, so Op is still the current instruction here.
            S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset forces every control low, including the MemReady-driven FETCH strobes.
    always_comb begin
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUOp    = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE:  ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD:   IorD = 1'b1;
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    Branch  = 1'b1;
                end
`ifdef MIPS_CTRL_ADDI_EN
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB:  RegWrite = 1'b1;
`endif
                S_JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign State     = state_q;
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Op = 6'b000000;
    logic       MemReady = 1'b1;
    logic       MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, IorD, RegWrite, RegDst, MemtoReg, IllegalOp;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic [3:0] State;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
        .State(State), .IllegalOp(IllegalOp)
    );

    // {MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, IorD, RegWrite, RegDst, MemtoReg, ALUOp}
    localparam logic [14:0] C_ZERO   = 15'b0;
    localparam logic [14:0] C_FETCH1 = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_FETCH0 = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_DECODE = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_MEMADR = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_MEMRD  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_MEMWB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    localparam logic [14:0] C_MEMWR  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_EXEC   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    localparam logic [14:0] C_ALUWB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
    localparam logic [14:0] C_BEQ    = {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    localparam logic [14:0] C_JUMP   = {1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [14:0] C_ADDIEX = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] C_ADDIWB = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
`endif

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BQ = 6'b000100;
    localparam logic [5:0] JP = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        int         tag;
        logic [3:0] st;
        logic [14:0] ctl;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;

    logic [14:0] act_ctl;
    assign act_ctl = {MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
                      IorD, RegWrite, RegDst, MemtoReg, ALUOp};

    // One cycle of stimulus: inputs applied just after the edge, expectation for this cycle queued.
    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [14:0] ctl, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rst;
        Op       = op;
        MemReady = mr;
        step_no++;
        e.tag = step_no;
        e.st  = st;
        e.ctl = ctl;
        e.ill = ill;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (State !== e.st || act_ctl !== e.ctl || IllegalOp !== e.ill) begin
                    failures++;
                    $display("FAIL step%0d: got state=%0d ctl=%b ill=%b, want state=%0d ctl=%b ill=%b",
                             e.tag, State, act_ctl, IllegalOp, e.st, e.ctl, e.ill);
                end
            end
        end
    end

    initial begin
        // reset held
        step(0, RT, 1, 0, C_ZERO, 0);
        step(0, RT, 1, 0, C_ZERO, 0);
        // lw: 0,1,2,3,4
        step(1, LW, 1, 0, C_FETCH1, 0);
        step(1, LW, 1, 1, C_DECODE, 0);
        step(1, LW, 1, 2, C_MEMADR, 0);
        step(1, LW, 1, 3, C_MEMRD,  0);
        step(1, LW, 1, 4, C_MEMWB,  0);
        // sw with MEMWR stalled two cycles
        step(1, SW, 1, 0, C_FETCH1, 0);
        step(1, SW, 1, 1, C_DECODE, 0);
        step(1, SW, 1, 2, C_MEMADR, 0);
        step(1, SW, 0, 5, C_MEMWR,  0);
        step(1, SW, 0, 5, C_MEMWR,  0);
        step(1, SW, 1, 5, C_MEMWR,  0);
        // R-type
        step(1, RT, 1, 0, C_FETCH1, 0);
        step(1, RT, 1, 1, C_DECODE, 0);
        step(1, RT, 1, 6, C_EXEC,   0);
        step(1, RT, 1, 7, C_ALUWB,  0);
        // beq
        step(1, BQ, 1, 0, C_FETCH1, 0);
        step(1, BQ, 1, 1, C_DECODE, 0);
        step(1, BQ, 1, 8, C_BEQ,    0);
        // stalled fetch then j
        step(1, JP, 0, 0, C_FETCH0, 0);
        step(1, JP, 0, 0, C_FETCH0, 0);
        step(1, JP, 0, 0, C_FETCH0, 0);
        step(1, JP, 1, 0, C_FETCH1, 0);
        step(1, JP, 1, 1, C_DECODE, 0);
        step(1, JP, 1, 11, C_JUMP,  0);
        // illegal opcode sets the sticky flag
        step(1, BAD, 1, 0, C_FETCH1, 0);
        step(1, BAD, 1, 1, C_DECODE, 0);
        // flag stays set through a legal lw; reset lands mid-MEMRD
        step(1, LW, 1, 0, C_FETCH1, 1);
        step(1, LW, 1, 1, C_DECODE, 1);
        step(1, LW, 1, 2, C_MEMADR, 1);
        step(1, LW, 0, 3, C_MEMRD,  1);
        step(0, LW, 1, 0, C_ZERO,   0);
        step(1, AI, 1, 0, C_FETCH1, 0);
        step(1, AI, 1, 1, C_DECODE, 0);
`ifdef MIPS_CTRL_ADDI_EN
        step(1, AI, 1, 9,  C_ADDIEX, 0);
        step(1, AI, 1, 10, C_ADDIWB, 0);
        step(1, RT, 1, 0,  C_FETCH1, 0);
`else
        step(1, RT, 1, 0, C_FETCH1, 1);
        step(1, RT, 1, 1, C_DECODE, 1);
        step(1, RT, 1, 6, C_EXEC,   1);
`endif
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
